// File: rtl/dostring_pkg.sv
// Shared definitions for the LED-string scroller and its doled SPI driver:
// element-type codes, scroller FSM states and the rainbow reset palette.
package dostring_pkg;

  typedef enum logic [1:0] {
    ELEM_START = 2'd0,
    ELEM_LED   = 2'd1,
    ELEM_END   = 2'd2
  } elem_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    LOAD,
    START,
    HOLD,
    ADVANCE
  } state_t;

  localparam int RAINBOW_LEN = 7;

  // {red, green, blue}; palette entries beyond seven repeat the sequence.
  function automatic logic [23:0] rainbow(input int idx);
    case (idx % RAINBOW_LEN)
      0:       return 24'h800280;
      1:       return 24'h0202f0;
      2:       return 24'h028080;
      3:       return 24'h02f002;
      4:       return 24'hf08002;
      5:       return 24'hc04002;
      default: return 24'hf00202;
    endcase
  endfunction

endpackage

// File: rtl/dostring_palette.sv
// Segment colour table: one write port, one combinational read port, and
// rainbow defaults restored on reset.
module dostring_palette
  import dostring_pkg::*;
#(
  parameter int SEG_NUMBER = 7,
  localparam int AW = $clog2(SEG_NUMBER)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_rgb,
  input  logic [AW-1:0] rd_addr,
  output logic [23:0]   rd_rgb
);

  logic [23:0] entry_reg [SEG_NUMBER];

  // Only addresses that match an existing entry are written, so
  // out-of-range writes fall through silently.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SEG_NUMBER; i++) begin
      if (srst) begin
        entry_reg[i] <= rainbow(i);
      end else if (we && wr_addr == AW'(i)) begin
        entry_reg[i] <= wr_rgb;
      end
    end
  end

  assign rd_rgb = entry_reg[rd_addr];

endmodule

// File: rtl/dostring_scroll.sv
// Streams START / STRING_SIZE LEDs / END frames to doled, colouring LEDs by
// palette segment and scrolling the segment pattern by one LED per step.
module dostring_scroll
  import dostring_pkg::*;
#(
  parameter int STRING_SIZE     = 46,
  parameter int SEG_SIZE        = 10,
  parameter int SEG_NUMBER      = 7,
  parameter int FRAMES_PER_STEP = 1,
  localparam int AW = $clog2(SEG_NUMBER)
) (
  input  logic          dostring_scroll_clk,
  input  logic          dostring_scroll_reset,
  input  logic          enable,
  input  logic          scroll_dir,
  input  logic          pal_we,
  input  logic [AW-1:0] pal_addr,
  input  logic [23:0]   pal_rgb,
  input  logic          led_busy,
  output logic          led_start,
  output logic [1:0]    led_type,
  output logic [7:0]    red_out,
  output logic [7:0]    green_out,
  output logic [7:0]    blue_out,
  output logic          frame_done
);

  localparam int PW = (SEG_SIZE > 1) ? $clog2(SEG_SIZE) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(SEG_SIZE - 1);
  localparam logic [AW-1:0] SEG_LAST = AW'(SEG_NUMBER - 1);
  localparam logic [7:0]    LED_LAST = 8'(STRING_SIZE - 1);
  localparam logic [7:0]    FPS_LAST = 8'(FRAMES_PER_STEP - 1);

  state_t        state_reg;
  elem_t         elem_reg;
  logic [AW-1:0] seg_reg, start_seg_reg, fwd_seg, off_seg_next;
  logic [PW-1:0] pos_reg, start_pos_reg, fwd_pos, off_pos_next;
  logic [7:0]    led_cnt_reg, frame_cnt_reg;
  logic          led_start_reg, frame_done_reg;
  logic [1:0]    led_type_reg;
  logic [23:0]   rgb_reg, pal_rd;

  dostring_palette #(.SEG_NUMBER(SEG_NUMBER)) u_palette (
    .clk     (dostring_scroll_clk),
    .srst    (dostring_scroll_reset),
    .we      (pal_we),
    .wr_addr (pal_addr),
    .wr_rgb  (pal_rgb),
    .rd_addr (seg_reg),
    .rd_rgb  (pal_rd)
  );

  // Next LED position inside the frame.
  always_comb begin
    fwd_seg = seg_reg;
    fwd_pos = pos_reg + 1'b1;
    if (pos_reg == POS_LAST) begin
      fwd_pos = '0;
      fwd_seg = (seg_reg == SEG_LAST) ? '0 : seg_reg + 1'b1;
    end
  end

  // Scroll offset one LED forward or back, wrapping at both ends.
  always_comb begin
    off_seg_next = start_seg_reg;
    off_pos_next = start_pos_reg;
    if (!scroll_dir) begin
      if (start_pos_reg == POS_LAST) begin
        off_pos_next = '0;
        off_seg_next = (start_seg_reg == SEG_LAST) ? '0 : start_seg_reg + 1'b1;
      end else begin
        off_pos_next = start_pos_reg + 1'b1;
      end
    end else begin
      if (start_pos_reg == '0) begin
        off_pos_next = POS_LAST;
        off_seg_next = (start_seg_reg == '0) ? SEG_LAST : start_seg_reg - 1'b1;
      end else begin
        off_pos_next = start_pos_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge dostring_scroll_clk) begin
    if (dostring_scroll_reset) begin
      state_reg      <= IDLE;
      elem_reg       <= ELEM_START;
      seg_reg        <= '0;
      pos_reg        <= '0;
      start_seg_reg  <= '0;
      start_pos_reg  <= '0;
      led_cnt_reg    <= '0;
      frame_cnt_reg  <= '0;
      led_start_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      led_type_reg   <= '0;
      rgb_reg        <= '0;
    end else begin
      led_start_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enable) begin
            elem_reg  <= ELEM_START;
            state_reg <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (!led_busy) state_reg <= LOAD;
        end
        LOAD: begin
          led_type_reg <= elem_reg;
          case (elem_reg)
            ELEM_START: rgb_reg <= 24'h000000;
            ELEM_LED:   rgb_reg <= pal_rd;
            default:    rgb_reg <= 24'hffffff;
          endcase
          led_start_reg <= 1'b1;
          state_reg     <= START;
        end
        START: state_reg <= HOLD;
        // Busy from doled is not yet valid here, so it is not looked at.
        HOLD: begin
          case (elem_reg)
            ELEM_START: begin
              elem_reg    <= ELEM_LED;
              seg_reg     <= start_seg_reg;
              pos_reg     <= start_pos_reg;
              led_cnt_reg <= '0;
              state_reg   <= WAIT_IDLE;
            end
            ELEM_LED: begin
              state_reg <= WAIT_IDLE;
              if (led_cnt_reg == LED_LAST) begin
                elem_reg <= ELEM_END;
              end else begin
                led_cnt_reg <= led_cnt_reg + 8'd1;
                seg_reg     <= fwd_seg;
                pos_reg     <= fwd_pos;
              end
            end
            default: begin
              frame_done_reg <= 1'b1;
              state_reg      <= ADVANCE;
            end
          endcase
        end
        ADVANCE: begin
          if (frame_cnt_reg == FPS_LAST) begin
            frame_cnt_reg <= '0;
            start_seg_reg <= off_seg_next;
            start_pos_reg <= off_pos_next;
          end else begin
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
          end
          elem_reg  <= ELEM_START;
          state_reg <= enable ? WAIT_IDLE : IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign led_start  = led_start_reg;
  assign frame_done = frame_done_reg;
  assign led_type   = led_type_reg;
  assign red_out    = rgb_reg[23:16];
  assign green_out  = rgb_reg[15:8];
  assign blue_out   = rgb_reg[7:0];

endmodule
